// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   jump_t  : jump_type encodings carried from the decoder
//   fwd_t   : operand forwarding select encodings
//   stage_t : per-stage control record kept for EX, MEM and WB
//   writes_reg() : true when a stage record produces a usable register write
package pipe_pkg;

  typedef enum logic [2:0] {
    JT_NONE = 3'b000,
    JT_BEQ  = 3'b001,
    JT_J    = 3'b010,
    JT_JR   = 3'b011
  } jump_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
    logic [2:0] jump_type;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // Register 0 is hard-wired, so a write to it is never a forwarding source.
  function automatic logic writes_reg(input stage_t s);
    return s.valid && s.we && (s.rd != 5'd0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decoder/datapath <-> hazard controller bundle.
//   ID-stage decode info, EX zero flag and memory stall flow into the
//   controller; hold/flush/bubble/redirect strobes, forwarding selects and
//   event counters flow back out.
//   master : the datapath side (drives decode info)
//   slave  : the hazard controller
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [4:0]       id_rs1_id;
  logic [4:0]       id_rs2_id;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rdst_id;
  logic             id_we_regfile;
  logic             id_is_load;
  logic [2:0]       id_jump_type;
  logic             ex_zero;
  logic             mem_stall;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             redirect;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1_id, id_rs2_id, id_use_rs1, id_use_rs2,
           id_rdst_id, id_we_regfile, id_is_load, id_jump_type,
           ex_zero, mem_stall,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, redirect,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1_id, id_rs2_id, id_use_rs1, id_use_rs2,
           id_rdst_id, id_we_regfile, id_is_load, id_jump_type,
           ex_zero, mem_stall,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, redirect,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fwd_sel.sv
// Forwarding select for one EX operand.
//   ex_rs/ex_use   : source register of the EX instruction and whether it is read
//   mem_wr/mem_rd  : MEM stage produces a register write, and its destination
//   wb_wr/wb_rd    : same for WB
//   sel            : FWD_MEM, FWD_WB or FWD_RF (MEM is the younger result and wins)
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic       ex_use,
  input  logic       mem_wr,
  input  logic [4:0] mem_rd,
  input  logic       wb_wr,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);

  // Pick the youngest in-flight producer of the operand; r0 never forwards.
  always_comb begin
    sel = FWD_RF;
    if (ex_use && (ex_rs != 5'd0) && mem_wr && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (ex_use && (ex_rs != 5'd0) && wb_wr && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS-style pipeline.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : pipeline_ctrl_if slave -- decode info in; hold/flush/bubble/
//              redirect strobes, forwarding selects and stall/flush event
//              counters out.
// Tracks EX/MEM/WB control records, resolves control and load-use hazards
// with priority mem_stall > EX redirect > load-use > ID jump, and forwards
// from MEM/WB into EX.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipeline_ctrl_if.slave bus
);

  stage_t           ex_q, mem_q, wb_q;
  stage_t           ex_d, mem_d, wb_d;
  stage_t           id_rec_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ex_redirect_s, load_use_s, id_redirect_s;
  logic             pc_hold_s, ifid_hold_s, ifid_flush_s, idex_bubble_s, redirect_s;
  logic             stall_evt_s;
  logic [1:0]       fwd_a_s, fwd_b_s;
  logic             rec_unused_s;

  // WB is the last stage: only its destination fields feed forwarding.
  assign rec_unused_s = ^wb_q;

  // Assemble the ID instruction into a stage record.
  always_comb begin
    id_rec_s           = STAGE_BUBBLE;
    id_rec_s.valid     = bus.id_valid;
    id_rec_s.rs1       = bus.id_rs1_id;
    id_rec_s.rs2       = bus.id_rs2_id;
    id_rec_s.use_rs1   = bus.id_use_rs1;
    id_rec_s.use_rs2   = bus.id_use_rs2;
    id_rec_s.rd        = bus.id_rdst_id;
    id_rec_s.we        = bus.id_we_regfile;
    id_rec_s.is_load   = bus.id_is_load;
    id_rec_s.jump_type = bus.id_jump_type;
  end

  // Raw hazard conditions before prioritisation.
  always_comb begin
    ex_redirect_s = ex_q.valid &&
                    (((ex_q.jump_type == JT_BEQ) && bus.ex_zero) ||
                     (ex_q.jump_type == JT_JR));
    load_use_s    = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1_id == ex_q.rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2_id == ex_q.rd)));
    id_redirect_s = bus.id_valid && (bus.id_jump_type == JT_J);
  end

  // Prioritised response; only the highest-priority event acts this cycle.
  always_comb begin
    pc_hold_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    redirect_s    = 1'b0;
    stall_evt_s   = 1'b0;
    if (rst) begin
      pc_hold_s = 1'b0;
    end else if (bus.mem_stall) begin
      pc_hold_s   = 1'b1;
      ifid_hold_s = 1'b1;
    end else if (ex_redirect_s) begin
      redirect_s    = 1'b1;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
    end else if (load_use_s) begin
      // One bubble suffices: next cycle the load sits in MEM and EX is empty.
      pc_hold_s     = 1'b1;
      ifid_hold_s   = 1'b1;
      idex_bubble_s = 1'b1;
      stall_evt_s   = 1'b1;
    end else if (id_redirect_s) begin
      redirect_s   = 1'b1;
      ifid_flush_s = 1'b1;
    end else begin
      pc_hold_s = 1'b0;
    end
  end

  // Next-state for stage records and saturating event counters.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.mem_stall) begin
      ex_d = ex_q;
    end else begin
      ex_d  = (idex_bubble_s || !bus.id_valid) ? STAGE_BUBBLE : id_rec_s;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (stall_evt_s && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (redirect_s && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= STAGE_BUBBLE;
      mem_q       <= STAGE_BUBBLE;
      wb_q        <= STAGE_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_sel u_fwd_a (
    .ex_rs  (ex_q.rs1),
    .ex_use (ex_q.use_rs1),
    .mem_wr (writes_reg(mem_q)),
    .mem_rd (mem_q.rd),
    .wb_wr  (writes_reg(wb_q)),
    .wb_rd  (wb_q.rd),
    .sel    (fwd_a_s)
  );

  fwd_sel u_fwd_b (
    .ex_rs  (ex_q.rs2),
    .ex_use (ex_q.use_rs2),
    .mem_wr (writes_reg(mem_q)),
    .mem_rd (mem_q.rd),
    .wb_wr  (writes_reg(wb_q)),
    .wb_rd  (wb_q.rd),
    .sel    (fwd_b_s)
  );

  // Every output reads as zero while reset is held.
  assign bus.pc_hold     = pc_hold_s;
  assign bus.ifid_hold   = ifid_hold_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.idex_bubble = idex_bubble_s;
  assign bus.redirect    = redirect_s;
  assign bus.fwd_a_sel   = rst ? FWD_RF : fwd_a_s;
  assign bus.fwd_b_sel   = rst ? FWD_RF : fwd_b_s;
  assign bus.stall_cnt   = rst ? '0 : stall_cnt_q;
  assign bus.flush_cnt   = rst ? '0 : flush_cnt_q;

endmodule
